// File: rtl/pipelined_fetch.sv
// Instruction-fetch stage: drives a level-request instruction memory, feeds the
// IF/ID register, buffers one word across decode stalls and drops stale responses after redirects.
module pipelined_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [ADDR_W-1:0]    PC_INC   = ADDR_W'(4)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               ifid_valid_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o,
  output logic [INSTR_W-1:0] ifid_instr_o
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    tgt_q, tgt_d;
  logic                 req_q, req_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0]    ifid_pc4_q, ifid_pc4_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]    skid_pc4_q, skid_pc4_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]    pc_inc_c;

  // State register; reset abandons any outstanding or buffered transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      req_q        <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      skid_pc4_q   <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      req_q        <= req_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Next-state logic; redirect outranks ack and stall in every state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;
    pc_inc_c     = pc_q + PC_INC;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          if (req_q && !imem_ack_i) begin
            // Memory still owes a response for the old address: wait it out
            state_d = ST_DISCARD;
            tgt_d   = redirect_pc_i;
          end else begin
            pc_d = redirect_pc_i;
          end
        end else if (req_q && imem_ack_i) begin
          if (stall_i) begin
            skid_pc4_d   = pc_inc_c;
            skid_instr_d = imem_rdata_i;
            state_d      = ST_HOLD;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_pc4_d   = pc_inc_c;
            ifid_instr_d = imem_rdata_i;
            pc_d         = pc_inc_c;
          end
        end else if (!stall_i) begin
          ifid_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          pc_d         = redirect_pc_i;
          skid_pc4_d   = '0;
          skid_instr_d = '0;
          state_d      = ST_FETCH;
        end else if (!stall_i) begin
          ifid_valid_d = 1'b1;
          ifid_pc4_d   = skid_pc4_q;
          ifid_instr_d = skid_instr_q;
          pc_d         = pc_inc_c;
          state_d      = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect_i) begin
          ifid_valid_d = 1'b0;
          if (imem_ack_i) begin
            pc_d    = redirect_pc_i;
            state_d = ST_FETCH;
          end else begin
            tgt_d = redirect_pc_i;
          end
        end else if (imem_ack_i) begin
          pc_d    = tgt_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    req_d = (state_d != ST_HOLD);
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;

endmodule

// File: tb/tb_pipelined_fetch.sv
// Bench for pipelined_fetch: directed scenarios plus random traffic, checked by a
// program-order scoreboard (every delivered word must be the next one on the current path).
module tb_pipelined_fetch;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;

  logic        rst8_n;
  logic        w8_req;
  logic [7:0]  w8_addr;
  logic        w8_valid;
  logic [7:0]  w8_pc4;
  logic [31:0] w8_instr;
  logic [31:0] w8_rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [31:0] exp_pc = 32'h40;

  pipelined_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h40), .PC_INC(32'd4)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .ifid_valid_o(ifid_valid_o),
    .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o)
  );

  // Narrow instance for address wrap, zero-wait memory
  assign w8_rdata = {24'h0, w8_addr};
  pipelined_fetch #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .PC_INC(8'd4)) u_w8 (
    .clk(clk), .rst_n(rst8_n), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(8'h00), .imem_req_o(w8_req), .imem_addr_o(w8_addr),
    .imem_ack_i(w8_req), .imem_rdata_i(w8_rdata), .ifid_valid_o(w8_valid),
    .ifid_pc4_o(w8_pc4), .ifid_instr_o(w8_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One cycle of stimulus; memory answers with the word for the current address
  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic a);
    exp_t e;
    @(negedge clk);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = t;
    imem_ack_i    = a && imem_req_o;
    imem_rdata_i  = imem_ack_i ? mem_word(imem_addr_o) : $urandom();
    if (r) begin
      sb.delete();
      exp_pc = t;
    end else if (imem_ack_i && imem_addr_o == exp_pc) begin
      e.pc4   = exp_pc + 32'd4;
      e.instr = mem_word(exp_pc);
      sb.push_back(e);
      exp_pc  = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with a stray ack present; everything in flight is forgotten
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n        = 1'b0;
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    sb.delete();
    exp_pc = 32'h40;
    repeat (n) @(negedge clk);
    rst_n      = 1'b1;
    imem_ack_i = 1'b0;
  endtask

  // Monitor: protocol checks and scoreboard pops whenever decode takes a word
  initial begin
    logic        p_rst = 1'b0, p_redir = 1'b0, p_req = 1'b0, p_ack = 1'b0;
    logic [31:0] p_addr = '0;
    int          since_rst = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(ifid_valid_o), 32'd0);
        chk("rst_pc4", ifid_pc4_o, 32'd0);
        chk("rst_instr", ifid_instr_o, 32'd0);
        since_rst = 0;
      end else begin
        since_rst++;
        if (since_rst == 1) chk("req_low_at_release", 32'(imem_req_o), 32'd0);
        if (since_rst == 2 && !p_redir) begin
          chk("first_req", 32'(imem_req_o), 32'd1);
          chk("first_addr", imem_addr_o, 32'h40);
        end
        if (p_rst && p_redir) chk("flush_after_redirect", 32'(ifid_valid_o), 32'd0);
        if (p_rst && p_req && !p_ack) begin
          chk("addr_stable", imem_addr_o, p_addr);
          chk("req_stable", 32'(imem_req_o), 32'd1);
        end
        if (ifid_valid_o && !stall_i && !redirect_i) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got pc4=%h instr=%h, expected no word", ifid_pc4_o, ifid_instr_o);
          end else begin
            e = sb.pop_front();
            chk("sb_pc4", ifid_pc4_o, e.pc4);
            chk("sb_instr", ifid_instr_o, e.instr);
          end
        end
      end
      p_rst   = rst_n;
      p_redir = redirect_i;
      p_req   = imem_req_o;
      p_ack   = imem_ack_i;
      p_addr  = imem_addr_o;
    end
  end

  initial begin
    logic        s, r, a;
    logic [31:0] t;
    rst_n = 1'b1; rst8_n = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    #1;
    rst_n = 1'b0; rst8_n = 1'b0;
    repeat (2) @(negedge clk);

    // 8-bit address wrap
    rst8_n = 1'b1;
    @(posedge clk); #1;
    chk("w8_addr0", 32'(w8_addr), 32'hF8);
    @(posedge clk); #1;
    chk("w8_pc4_a", 32'(w8_pc4), 32'hFC);
    chk("w8_instr_a", w8_instr, 32'hF8);
    @(posedge clk); #1;
    chk("w8_pc4_wrap", 32'(w8_pc4), 32'h00);
    chk("w8_addr_wrap", 32'(w8_addr), 32'h00);
    chk("w8_valid", 32'(w8_valid), 32'd1);

    // Zero-wait streaming from reset
    do_reset(2);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("stream_pc4", ifid_pc4_o, 32'h40 + 32'(4 * i));
      chk("stream_valid", 32'(ifid_valid_o), 32'd1);
    end

    // Late ack at 0x40
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      chk("late_addr", imem_addr_o, 32'h40);
      chk("late_bubble", 32'(ifid_valid_o), 32'd0);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    chk("late_pc4", ifid_pc4_o, 32'h44);

    // Stall across an ack at 0x48
    step(1'b0, 1'b0, '0, 1'b1);
    chk("pre_stall_pc4", ifid_pc4_o, 32'h48);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      chk("stall_hold_pc4", ifid_pc4_o, 32'h48);
      chk("stall_hold_instr", ifid_instr_o, mem_word(32'h44));
      chk("hold_req", 32'(imem_req_o), 32'd0);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    chk("release_pc4", ifid_pc4_o, 32'h4C);
    chk("release_instr", ifid_instr_o, mem_word(32'h48));
    chk("release_addr", imem_addr_o, 32'h4C);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("after_release_pc4", ifid_pc4_o, 32'h50);

    // Redirect while 0x50 is outstanding
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    chk("discard_addr", imem_addr_o, 32'h50);
    chk("discard_valid", 32'(ifid_valid_o), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("discard_addr2", imem_addr_o, 32'h50);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("dropped_valid", 32'(ifid_valid_o), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("redir_pc4", ifid_pc4_o, 32'h104);
    chk("redir_instr", ifid_instr_o, mem_word(32'h100));

    // Two redirects while discarding: only the later one is fetched
    step(1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("latest_target", imem_addr_o, 32'h300);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("latest_pc4", ifid_pc4_o, 32'h304);

    // Redirect together with stall and ack
    step(1'b1, 1'b1, 32'h180, 1'b1);
    chk("redir_stall_valid", 32'(ifid_valid_o), 32'd0);
    chk("redir_stall_addr", imem_addr_o, 32'h180);

    // Reset while a word is buffered
    step(1'b1, 1'b0, '0, 1'b1);
    chk("hold_before_rst", 32'(imem_req_o), 32'd0);
    do_reset(2);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("post_rst_pc4", ifid_pc4_o, 32'h44);
    chk("post_rst_instr", ifid_instr_o, mem_word(32'h40));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset(1 + int'($urandom_range(1)));
      end else begin
        s = ($urandom_range(3) == 0);
        r = ($urandom_range(15) == 0);
        a = ($urandom_range(2) != 0);
        t = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3))
                                     : ($urandom() & 32'h0000_FFFC);
        if (t == imem_addr_o) t = t + 32'h1000;
        step(s, r, t, a);
      end
    end

    // Drain: every accepted word must reach decode
    repeat (4) step(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #3;
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_fetch.md
PIPELINED_FETCH -- requirements
Module: pipelined_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, PC and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 Parameter PC_INC, default 4, sequential PC increment.
REQ-005 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port stall_i  input  1  decode requests that the IF/ID register hold its contents.
REQ-008 Port redirect_i  input  1  branch or jump taken; flush and reload the PC.
REQ-009 Port redirect_pc_i  input  ADDR_W  redirect target.
REQ-010 Port imem_req_o  output  1  instruction-memory request, level.
REQ-011 Port imem_addr_o  output  ADDR_W  fetch address, equal to the PC.
REQ-012 Port imem_ack_i  input  1  instruction-memory data valid for the current request.
REQ-013 Port imem_rdata_i  input  INSTR_W  fetched instruction, sampled only when imem_ack_i=1.
REQ-014 Port ifid_valid_o  output  1  IF/ID register holds a real instruction.
REQ-015 Port ifid_pc4_o  output  ADDR_W  IF/ID incremented PC (fetch PC + PC_INC).
REQ-016 Port ifid_instr_o  output  INSTR_W  IF/ID instruction.

Function
REQ-017 The FSM SHALL have three states: FETCH (imem_req_o=1), HOLD (imem_req_o=0, fetched word buffered), DISCARD (imem_req_o=1, address frozen, response to be dropped).
REQ-018 imem_addr_o SHALL stay constant while imem_req_o=1 and imem_ack_i=0.
REQ-019 In FETCH with ack=1, stall=0, redirect=0: IF/ID SHALL load {pc+PC_INC, rdata}, valid=1, and PC SHALL advance by PC_INC. The state SHALL stay FETCH, giving a throughput of one instruction per cycle with a zero-wait memory.
REQ-020 In FETCH with ack=0, stall=0, redirect=0: ifid_valid_o SHALL go to 0 (bubble) and PC SHALL hold.
REQ-021 If stall=1 and redirect=0 in any state, the IF/ID register (valid, pc4, instr) SHALL hold its value.
REQ-022 In FETCH with ack=1, stall=1, redirect=0: rdata and pc+PC_INC SHALL be captured into a skid buffer and the FSM SHALL enter HOLD.
REQ-023 In HOLD with stall=0, redirect=0: IF/ID SHALL load the skid buffer with valid=1, PC SHALL advance by PC_INC, and the FSM SHALL enter FETCH.
REQ-024 redirect_i SHALL take priority over stall_i and ack in every state. On redirect, ifid_valid_o SHALL be 0 on the next cycle and PC SHALL load redirect_pc_i. Any skid-buffer content SHALL be discarded.
REQ-025 If redirect occurs in FETCH with ack=0, the FSM SHALL enter DISCARD and the old address SHALL be held until ack. That ack's data SHALL be dropped, and the next cycle SHALL issue the request at the redirect PC in FETCH.
REQ-026 In DISCARD, a further redirect SHALL overwrite the pending target. Only the latest target SHALL be fetched.
REQ-027 Redirect in FETCH with ack=1, or in HOLD, SHALL go directly to FETCH at the new PC with no discard.
REQ-028 Redirect SHALL override stall: IF/ID is flushed even while stall_i=1.
REQ-029 PC arithmetic SHALL be modulo 2^ADDR_W and SHALL wrap silently.
REQ-030 ifid_pc4_o SHALL also wrap modulo 2^ADDR_W.
REQ-031 No output SHALL depend combinationally on stall_i, redirect_i or imem_ack_i.
REQ-032 imem_req_o and imem_addr_o SHALL be functions of state and PC only.

Reset
REQ-033 While rst_n=0: PC=RESET_PC, state FETCH, imem_req_o=0, ifid_valid_o=0, ifid_pc4_o=0, ifid_instr_o=0, skid buffer cleared.
REQ-034 imem_req_o SHALL first assert in the cycle after rst_n deasserts, with imem_addr_o=RESET_PC.
REQ-035 Reset asserted mid-request or in HOLD/DISCARD SHALL abandon the transaction immediately. An ack arriving during reset SHALL be ignored.

Verification
REQ-036 Zero-wait memory (ack tied 1), RESET_PC=0x40, 4 cycles -> IF/ID pc4 = 0x44, 0x48, 0x4C, 0x50 on consecutive cycles, valid=1 throughout.
REQ-037 Ack delayed 2 cycles at addr 0x40 -> imem_addr_o holds 0x40 for 3 cycles, ifid_valid_o=0 for 2 cycles, then pc4=0x44.
REQ-038 Stall asserted for 3 cycles coinciding with an ack at 0x48 -> IF/ID holds the 0x48 word's predecessor, imem_req_o=0 in HOLD. After release, IF/ID shows pc4=0x4C with the buffered word; no word is lost or duplicated.
REQ-039 Redirect to 0x100 while the request at 0x50 is pending (ack late) -> address held at 0x50 until ack, that data dropped, next request at 0x100, ifid_valid_o=0 until the 0x100 word arrives.
REQ-040 Redirect and stall in the same cycle -> ifid_valid_o=0 next cycle, PC=target.
REQ-041 ADDR_W=8, PC=0xFC, PC_INC=4 -> next PC=0x00 and ifid_pc4_o=0x00.
REQ-042 Reset pulsed in HOLD -> all outputs zero, the next request is at RESET_PC, and the buffered word never appears on IF/ID.
